// File: rtl/conv_transposed_1d_scheduler.sv
// Address sequencer for a transposed 1D convolution MAC datapath: scans (oc, o, ic, k), issues MACs then one FLUSH per output.
// Optional macro CONV_T1D_SCHED_PERF_EN builds the MAC/stall performance counters.
module conv_transposed_1d_scheduler #(
  parameter int IN_CH   = 2,
  parameter int OUT_CH  = 2,
  parameter int IN_LEN  = 4,
  parameter int KERNEL  = 3,
  parameter int STRIDE  = 2,
  parameter int PADDING = 0,
  parameter int OUT_PAD = 0,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic              iss_op,
  output logic [ADDR_W-1:0] iss_in_addr,
  output logic [ADDR_W-1:0] iss_w_addr,
  output logic [ADDR_W-1:0] iss_out_addr,
  output logic [31:0]       perf_mac_cnt,
  output logic [31:0]       perf_stall_cnt
);
  localparam int L_OUT = (IN_LEN - 1) * STRIDE - 2 * PADDING + KERNEL + OUT_PAD;
  // t = o + PADDING - k is kept as floor quotient / remainder by STRIDE; these seed o = 0
  localparam int REM0 = PADDING % STRIDE;
  localparam int QUO0 = PADDING / STRIDE;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_HOLD, S_FLUSH, S_DONE} state_t;

  state_t             state_reg;
  logic [31:0]        oc_reg, o_reg, ic_reg, k_reg;
  logic [31:0]        rem_o_reg, rem_reg;
  logic signed [31:0] quo_o_reg, quo_reg;
  logic [31:0]        rem_o_next;
  logic signed [31:0] quo_o_next;

  logic tap_valid, mac_valid, step_cand;

  assign tap_valid = (rem_reg == 32'd0) && (quo_reg >= 0) && (quo_reg < IN_LEN);
  assign mac_valid = ((state_reg == S_SCAN) && tap_valid) || (state_reg == S_HOLD);
  assign step_cand = ((state_reg == S_SCAN) && (!tap_valid || iss_ready)) ||
                     ((state_reg == S_HOLD) && iss_ready);

  assign iss_valid = mac_valid || (state_reg == S_FLUSH);
  assign iss_op    = (state_reg == S_FLUSH);
  assign busy      = (state_reg == S_SCAN) || (state_reg == S_HOLD) || (state_reg == S_FLUSH);
  assign done      = (state_reg == S_DONE);

  always_comb begin
    rem_o_next = rem_o_reg + 32'd1;
    quo_o_next = quo_o_reg;
    if (rem_o_reg == 32'(STRIDE - 1)) begin
      rem_o_next = 32'd0;
      quo_o_next = quo_o_reg + 32'sd1;
    end
  end

  always_comb begin
    iss_in_addr  = '0;
    iss_w_addr   = '0;
    iss_out_addr = '0;
    if (mac_valid) begin
      iss_in_addr = ADDR_W'(ic_reg * IN_LEN) + ADDR_W'(quo_reg);
      iss_w_addr  = ADDR_W'((ic_reg * OUT_CH + oc_reg) * KERNEL + k_reg);
    end
    if (iss_valid) begin
      iss_out_addr = ADDR_W'(oc_reg * L_OUT + o_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      oc_reg    <= '0;
      o_reg     <= '0;
      ic_reg    <= '0;
      k_reg     <= '0;
      rem_o_reg <= '0;
      rem_reg   <= '0;
      quo_o_reg <= '0;
      quo_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_SCAN;
            oc_reg    <= '0;
            o_reg     <= '0;
            ic_reg    <= '0;
            k_reg     <= '0;
            rem_o_reg <= 32'(REM0);
            rem_reg   <= 32'(REM0);
            quo_o_reg <= 32'(QUO0);
            quo_reg   <= 32'(QUO0);
          end
        end
        S_SCAN, S_HOLD: begin
          if (step_cand) begin
            state_reg <= S_SCAN;
            if (k_reg == 32'(KERNEL - 1)) begin
              k_reg   <= '0;
              rem_reg <= rem_o_reg;
              quo_reg <= quo_o_reg;
              if (ic_reg == 32'(IN_CH - 1)) begin
                ic_reg    <= '0;
                state_reg <= S_FLUSH;
              end else begin
                ic_reg <= ic_reg + 32'd1;
              end
            end else begin
              // next tap lowers t by one
              k_reg <= k_reg + 32'd1;
              if (rem_reg == 32'd0) begin
                rem_reg <= 32'(STRIDE - 1);
                quo_reg <= quo_reg - 32'sd1;
              end else begin
                rem_reg <= rem_reg - 32'd1;
              end
            end
          end else if (state_reg == S_SCAN) begin
            state_reg <= S_HOLD;
          end
        end
        S_FLUSH: begin
          if (iss_ready) begin
            state_reg <= S_SCAN;
            if (o_reg == 32'(L_OUT - 1)) begin
              o_reg     <= '0;
              rem_o_reg <= 32'(REM0);
              rem_reg   <= 32'(REM0);
              quo_o_reg <= 32'(QUO0);
              quo_reg   <= 32'(QUO0);
              if (oc_reg == 32'(OUT_CH - 1)) begin
                oc_reg    <= '0;
                state_reg <= S_DONE;
              end else begin
                oc_reg <= oc_reg + 32'd1;
              end
            end else begin
              o_reg     <= o_reg + 32'd1;
              rem_o_reg <= rem_o_next;
              rem_reg   <= rem_o_next;
              quo_o_reg <= quo_o_next;
              quo_reg   <= quo_o_next;
            end
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef CONV_T1D_SCHED_PERF_EN
  logic [31:0] mac_cnt_reg, stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      mac_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
    end else if ((state_reg == S_IDLE) && start) begin
      mac_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (mac_valid && iss_ready) mac_cnt_reg <= mac_cnt_reg + 32'd1;
      if (iss_valid && !iss_ready) stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign perf_mac_cnt   = mac_cnt_reg;
  assign perf_stall_cnt = stall_cnt_reg;
`else
  assign perf_mac_cnt   = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: doc/conv_transposed_1d_scheduler.md
Name: conv_transposed_1d_scheduler

Overview:
- Address-sequencing controller for the transposed 1D convolution MAC datapath.
- Walks every output element and emits MAC operations for each contributing input/weight pair, then one FLUSH operation that tells the datapath to write its accumulator and clear it.
- Sits between the layer-level control (start/done) and the MAC datapath; groups=1, no bias.
- One candidate (input channel, tap) pair is evaluated per cycle, so the scan schedule is fully deterministic.

Parameters:
IN_CH, 2, input channels
OUT_CH, 2, output channels
IN_LEN, 4, input length
KERNEL, 3, kernel size
STRIDE, 2, stride (>=1)
PADDING, 0, padding
OUT_PAD, 0, output padding (< STRIDE)
ADDR_W, 16, width of every address output

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a layer when idle
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last FLUSH is accepted
iss_valid  out  1  issue operation valid
iss_ready  in  1  datapath accepts the operation
iss_op  out  1  0 = MAC, 1 = FLUSH
iss_in_addr  out  ADDR_W  ic*IN_LEN + i (MAC only)
iss_w_addr  out  ADDR_W  (ic*OUT_CH + oc)*KERNEL + k (MAC only)
iss_out_addr  out  ADDR_W  oc*L_OUT + o
perf_mac_cnt  out  32  MACs issued in the current or last layer
perf_stall_cnt  out  32  cycles with iss_valid=1 and iss_ready=0

Behaviour:
- Derived value: L_OUT = (IN_LEN-1)*STRIDE - 2*PADDING + KERNEL + OUT_PAD, computed at elaboration.
- Reset: state IDLE. busy, done and iss_valid are 0. All addresses, iss_op and perf counters are 0.
- Loop order, outermost first: oc, o (0..L_OUT-1), ic, k.
- For each candidate, t = o + PADDING - k.
  - Valid when t >= 0, t mod STRIDE == 0, and i = t/STRIDE < IN_LEN.
  - t, the remainder and i are tracked incrementally with counters. No divider is allowed.
- FSM states:
  - IDLE: on start, go to SCAN with all indices = 0 and perf counters cleared; busy=1 from the next cycle.
  - SCAN: evaluate one candidate per cycle.
    - Invalid candidate: iss_valid=0, advance to the next candidate.
    - Valid candidate: iss_valid=1, iss_op=0, addresses driven combinationally from the indices.
      - If iss_ready=1, advance in the same cycle.
      - Otherwise go to HOLD.
    - After the last (ic,k) for an output, go to FLUSH.
  - HOLD: keep iss_valid and all issue fields stable until iss_ready=1, then advance as in SCAN.
  - FLUSH: iss_valid=1, iss_op=1, iss_out_addr for the current (oc,o); in_addr and w_addr held at 0.
    - On accept, go to the next o, or the next oc.
    - After the last output of the last oc, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Timing with iss_ready held at 1: each output takes exactly IN_CH*KERNEL + 1 cycles.
  - Layer latency from the start cycle to the done pulse = OUT_CH*L_OUT*(IN_CH*KERNEL+1) + 1 cycles.
- An output with no valid taps still gets exactly one FLUSH.
- Boundary conditions:
  - start while busy: ignored.
  - start and rst in the same cycle: rst wins.
  - rst mid-layer: return to IDLE next cycle, iss_valid=0, no done pulse; the datapath accumulator is the datapath's concern.
- Counter and address widths: counters wrap modulo 2^32. Address arithmetic is truncated to ADDR_W.
- iss_valid must never drop, and no issue field may change, while iss_ready=0 (AXI-style stability).

Optional Feature:
- Macro: CONV_T1D_SCHED_PERF_EN.
- Defined: perf_mac_cnt increments on each accepted MAC. perf_stall_cnt increments on each cycle with iss_valid=1 and iss_ready=0. Both clear on an accepted start and hold their values after done.
- Undefined: both ports are driven constant 0 and no counter registers are built.

Test Plan:
1. Defaults with IN_CH=OUT_CH=1 (L_OUT=9), iss_ready=1.
   - o=0 issues MAC(in0,w0) then FLUSH(out0).
   - o=2 issues MAC(in1,w0), MAC(in0,w2), FLUSH(out2).
   - Total 12 MACs and 9 FLUSHes; done exactly 37 cycles after start.
2. PADDING=1, IN_CH=OUT_CH=1 (L_OUT=7).
   - o=0 issues only MAC(in0,w1) then FLUSH(out0).
   - Total 10 MACs (edge taps excluded), 7 FLUSHes.
3. STRIDE=3, KERNEL=2, IN_CH=OUT_CH=1 (L_OUT=11).
   - o=2 issues FLUSH(out2) with no MAC.
   - Total 8 MACs, 11 FLUSHes.
4. Defaults with iss_ready toggling pseudo-randomly.
   - Issue sequence identical to the iss_ready=1 run.
   - Fields stable throughout every stall.
   - With CONV_T1D_SCHED_PERF_EN: perf_stall_cnt equals the counted stall cycles and perf_mac_cnt=48.
5. Assert rst three cycles after the 5th FLUSH.
   - Next cycle: iss_valid=0, busy=0, no done pulse.
   - A fresh start then reproduces the run from test 4 from the beginning.
6. Pulse start again while busy.
   - Ignored; sequence and done timing unchanged.
   - done pulse is exactly one cycle wide.
